// File: rtl/puf_hash_uart_tx_if.sv
// Bundle between the PUF hash stage (master) and the ASCII-hex UART logger (slave).
interface puf_hash_uart_tx_if;
    logic         valid;
    logic [5:0]   challenge;
    logic [7:0]   response;
    logic [127:0] hash;
    logic         tx;
    logic         busy;
    logic         sent;

    modport master (output valid, challenge, response, hash, input tx, busy, sent);
    modport slave  (input valid, challenge, response, hash, output tx, busy, sent);
endinterface

// File: rtl/puf_hash_uart_tx.sv
// Snapshots challenge/response/hash on a valid rising edge and streams them as one
// 40-char ASCII-hex line ("CC:RR:<32 hex>\r\n") over an 8N1 UART.
module puf_hash_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic              clk,
    input  logic              rst,
    puf_hash_uart_tx_if.slave bus
);
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W  = 6;
    localparam int unsigned SNAP_W = 142;
    localparam logic [IDX_W-1:0]  LAST_CHAR = IDX_W'(39);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_DONE} state_e;

    state_e              state_q, state_d;
    logic [SNAP_W-1:0]   snap_q, snap_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [2:0]          bit_q, bit_d;
    logic [IDX_W-1:0]    char_q, char_d;
    logic                pending_q, pending_d;
    logic                valid_prev_q, valid_prev_d;
    logic                tx_q, tx_d;
    logic                busy_q, busy_d;
    logic                sent_q, sent_d;

    logic                rise_c, bit_end_c, in_frame_c, launch_c;
    logic [2:0]          bit_nx_c;
    logic [4:0]          nib_idx_c;
    logic [127:0]        snap_hash_c;
    logic [7:0]          char_byte_c;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + 8'(n)) : (8'h37 + 8'(n));
    endfunction

    assign rise_c      = bus.valid & ~valid_prev_q;
    assign bit_end_c   = (baud_q == BAUD_LAST);
    assign in_frame_c  = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);
    assign bit_nx_c    = bit_q + 3'd1;
    // Edge in DONE counts as pending so a coincident edge is never dropped.
    assign launch_c    = ((state_q == S_IDLE) && rise_c) ||
                         ((state_q == S_DONE) && (pending_q || rise_c) && bus.valid);
    assign snap_hash_c = snap_q[127:0];

    // Character currently on the wire, selected from the snapshot by char index.
    always_comb begin
        nib_idx_c = 5'(char_q - IDX_W'(6));
        case (char_q)
            6'd0:    char_byte_c = hex_ascii({2'b00, snap_q[141:140]});
            6'd1:    char_byte_c = hex_ascii(snap_q[139:136]);
            6'd2:    char_byte_c = 8'h3A;
            6'd3:    char_byte_c = hex_ascii(snap_q[135:132]);
            6'd4:    char_byte_c = hex_ascii(snap_q[131:128]);
            6'd5:    char_byte_c = 8'h3A;
            6'd38:   char_byte_c = 8'h0D;
            6'd39:   char_byte_c = 8'h0A;
            default: char_byte_c = hex_ascii(snap_hash_c[{~nib_idx_c, 2'b00} +: 4]);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (launch_c) state_d = S_START;
            S_START: if (bit_end_c) state_d = S_DATA;
            S_DATA:  if (bit_end_c && (bit_q == 3'd7)) state_d = S_STOP;
            S_STOP:  if (bit_end_c) state_d = (char_q == LAST_CHAR) ? S_DONE : S_START;
            S_DONE:  state_d = launch_c ? S_START : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        snap_d       = snap_q;
        baud_d       = baud_q;
        bit_d        = bit_q;
        char_d       = char_q;
        pending_d    = pending_q;
        valid_prev_d = bus.valid;
        tx_d         = tx_q;
        busy_d       = busy_q;
        sent_d       = 1'b0;
        if (launch_c) begin
            snap_d    = {bus.challenge, bus.response, bus.hash};
            baud_d    = '0;
            bit_d     = '0;
            char_d    = '0;
            pending_d = 1'b0;
            tx_d      = 1'b0;
            busy_d    = 1'b1;
        end else begin
            if (in_frame_c) begin
                baud_d = bit_end_c ? '0 : BAUD_W'(baud_q + 1'b1);
                if (rise_c) pending_d = 1'b1;
            end
            case (state_q)
                S_START: if (bit_end_c) begin
                    bit_d = '0;
                    tx_d  = char_byte_c[0];
                end
                S_DATA: if (bit_end_c) begin
                    if (bit_q == 3'd7) begin
                        tx_d = 1'b1;
                    end else begin
                        bit_d = bit_nx_c;
                        tx_d  = char_byte_c[bit_nx_c];
                    end
                end
                S_STOP: if (bit_end_c) begin
                    if (char_q == LAST_CHAR) begin
                        tx_d   = 1'b1;
                        busy_d = 1'b0;
                        sent_d = 1'b1;
                    end else begin
                        char_d = IDX_W'(char_q + 1'b1);
                        tx_d   = 1'b0;
                    end
                end
                S_DONE: begin
                    pending_d = 1'b0;
                    busy_d    = 1'b0;
                    tx_d      = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // valid_prev resets high so a valid already asserted at release does not fire.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_q       <= '0;
            baud_q       <= '0;
            bit_q        <= '0;
            char_q       <= '0;
            pending_q    <= 1'b0;
            valid_prev_q <= 1'b1;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            sent_q       <= 1'b0;
        end else begin
            snap_q       <= snap_d;
            baud_q       <= baud_d;
            bit_q        <= bit_d;
            char_q       <= char_d;
            pending_q    <= pending_d;
            valid_prev_q <= valid_prev_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            sent_q       <= sent_d;
        end
    end

    assign bus.tx   = tx_q;
    assign bus.busy = busy_q;
    assign bus.sent = sent_q;
endmodule

// File: tb/tb_puf_hash_uart_tx.sv
// Randomized bench for puf_hash_uart_tx: a UART receiver model decodes tx and the
// decoded bytes are compared with lines formatted from the captured inputs.
module tb_puf_hash_uart_tx;
    localparam int unsigned C     = 4;
    localparam int unsigned FRAME = 400 * C;

    logic        clk = 1'b0;
    logic        rst;
    int unsigned cyc = 0;

    puf_hash_uart_tx_if bus ();
    puf_hash_uart_tx #(.CLKS_PER_BIT(C)) u_dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    int unsigned busy_cnt = 0, sent_cnt = 0, ferr_cnt = 0;
    int unsigned sent_cyc[$];
    logic [7:0]  rx_bytes[$];
    int unsigned rx_start[$];
    logic [7:0]  exp_bytes[$];
    int unsigned busy_b, sent_b, ferr_b, rx_b, scyc_b;

    always @(negedge clk) begin
        if (bus.busy === 1'b1) busy_cnt <= busy_cnt + 1;
        if (bus.sent === 1'b1) begin
            sent_cnt <= sent_cnt + 1;
            sent_cyc.push_back(cyc);
        end
    end

    // 8N1 receiver: start detected on the first negedge of the start bit, bits sampled mid-bit.
    initial begin : uart_rx
        logic [7:0]  b;
        int unsigned t0;
        logic        ok;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && bus.tx === 1'b0) begin
                t0 = cyc;
                ok = 1'b1;
                repeat (C / 2) @(negedge clk);
                if (bus.tx !== 1'b0) ok = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    repeat (C) @(negedge clk);
                    b[i] = bus.tx;
                end
                repeat (C) @(negedge clk);
                if (bus.tx !== 1'b1) ok = 1'b0;
                rx_bytes.push_back(b);
                rx_start.push_back(t0);
                if (!ok) ferr_cnt++;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic steps(input int unsigned n);
        repeat (n) step();
    endtask

    task automatic clear_mon();
        busy_b = busy_cnt;
        sent_b = sent_cnt;
        ferr_b = ferr_cnt;
        rx_b   = rx_bytes.size();
        scyc_b = sent_cyc.size();
        exp_bytes.delete();
    endtask

    // Reference line: "CC:RR:" + 32 uppercase hex digits of hash + CR LF.
    task automatic push_exp(input logic [5:0] c, input logic [7:0] r, input logic [127:0] h);
        string      digits;
        logic [7:0] c8;
        digits = "0123456789ABCDEF";
        c8 = {2'b00, c};
        exp_bytes.push_back(digits[c8[7:4]]);
        exp_bytes.push_back(digits[c8[3:0]]);
        exp_bytes.push_back(8'h3A);
        exp_bytes.push_back(digits[r[7:4]]);
        exp_bytes.push_back(digits[r[3:0]]);
        exp_bytes.push_back(8'h3A);
        for (int i = 0; i < 32; i++) exp_bytes.push_back(digits[h[127 - 4 * i -: 4]]);
        exp_bytes.push_back(8'h0D);
        exp_bytes.push_back(8'h0A);
    endtask

    task automatic trigger(input logic [5:0] c, input logic [7:0] r, input logic [127:0] h,
                           output int unsigned k);
        bus.valid = 1'b0;
        step();
        bus.challenge = c;
        bus.response  = r;
        bus.hash      = h;
        bus.valid     = 1'b1;
        k = cyc + 1;
    endtask

    task automatic wait_sent(input int unsigned target, input int unsigned budget, input string tag);
        int unsigned n;
        n = 0;
        while ((sent_cnt - sent_b) < target && n < budget) begin
            step();
            n++;
        end
        check({tag, "_sent_count"}, 64'(sent_cnt - sent_b), 64'(target));
    endtask

    function automatic int unsigned start_of(input int unsigned f);
        if (rx_b + 40 * f < rx_start.size()) return rx_start[rx_b + 40 * f];
        return 32'hFFFF_FFFF;
    endfunction

    function automatic int unsigned sent_at(input int unsigned i);
        if (scyc_b + i < sent_cyc.size()) return sent_cyc[scyc_b + i];
        return 32'hFFFF_FFFF;
    endfunction

    task automatic compare_rx(input string tag);
        int unsigned n, bad;
        logic [15:0] got;
        n   = rx_bytes.size() - rx_b;
        bad = 0;
        check({tag, "_len"}, 64'(n), 64'(exp_bytes.size()));
        for (int i = 0; i < exp_bytes.size(); i++) begin
            got = (i < n) ? {8'h00, rx_bytes[rx_b + i]} : 16'hFFFF;
            check($sformatf("%s_char%0d", tag, i), 64'(got), 64'(exp_bytes[i]));
        end
        for (int j = 1; j < n; j++)
            if ((j % 40) != 0 && (rx_start[rx_b + j] - rx_start[rx_b + j - 1]) != 10 * C) bad++;
        check({tag, "_char_spacing"}, 64'(bad), 64'd0);
        check({tag, "_framing"}, 64'(ferr_cnt - ferr_b), 64'd0);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin : main
        logic [5:0]   c;
        logic [7:0]   r;
        logic [127:0] h;
        int unsigned  k, t1, t2, t3, t4;

        rst = 1'b1;
        bus.valid = 1'b0;
        bus.challenge = '0;
        bus.response = '0;
        bus.hash = '0;
        steps(3);
        check("reset_tx", 64'(bus.tx), 64'd1);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_sent", 64'(bus.sent), 64'd0);
        rst = 1'b0;
        steps(3);

        // Basic frame with fixed values.
        clear_mon();
        trigger(6'h2A, 8'hC3, 128'h0123456789ABCDEF_FEDCBA9876543210, k);
        push_exp(6'h2A, 8'hC3, 128'h0123456789ABCDEF_FEDCBA9876543210);
        wait_sent(1, FRAME + 50, "basic");
        steps(4);
        check("basic_busy_cycles", 64'(busy_cnt - busy_b), 64'(FRAME));
        check("basic_sent_offset", 64'(sent_at(0) - k), 64'(FRAME));
        check("basic_start_offset", 64'(start_of(0) - k), 64'd0);
        compare_rx("basic");

        // Inputs change and valid drops after capture.
        clear_mon();
        trigger(6'h2A, 8'hC3, 128'h0123456789ABCDEF_FEDCBA9876543210, k);
        push_exp(6'h2A, 8'hC3, 128'h0123456789ABCDEF_FEDCBA9876543210);
        steps(101);
        bus.hash  = '1;
        bus.valid = 1'b0;
        wait_sent(1, FRAME, "snap");
        steps(2000);
        check("snap_frames", 64'(sent_cnt - sent_b), 64'd1);
        compare_rx("snap");

        // valid held high: one frame only.
        clear_mon();
        c = 6'($urandom); r = 8'($urandom); h = rnd128();
        trigger(c, r, h, k);
        push_exp(c, r, h);
        steps(5000);
        check("held_frames", 64'(sent_cnt - sent_b), 64'd1);
        check("held_busy_cycles", 64'(busy_cnt - busy_b), 64'(FRAME));
        compare_rx("held");
        bus.valid = 1'b0;
        steps(2);

        // Several edges mid-frame collapse into one pending frame with fresh inputs.
        clear_mon();
        c = 6'($urandom); r = 8'($urandom); h = rnd128();
        trigger(c, r, h, k);
        push_exp(c, r, h);
        t1 = $urandom_range(400, 50);
        t2 = t1 + $urandom_range(300, 10);
        t3 = t2 + $urandom_range(300, 10);
        t4 = t3 + $urandom_range(300, 10);
        steps(t1);      bus.valid = 1'b0;
        steps(t2 - t1); bus.valid = 1'b1;
        steps(t3 - t2); bus.valid = 1'b0;
        c = 6'($urandom); r = 8'h5E; h = rnd128();
        bus.challenge = c; bus.response = r; bus.hash = h;
        steps(t4 - t3); bus.valid = 1'b1;
        push_exp(c, r, h);
        wait_sent(2, 2 * FRAME + 100, "pend");
        steps(4);
        check("pend_gap", 64'(start_of(1) - sent_at(0)), 64'd1);
        check("pend_busy_cycles", 64'(busy_cnt - busy_b), 64'(2 * FRAME));
        compare_rx("pend");
        steps(2000);
        check("pend_total_frames", 64'(sent_cnt - sent_b), 64'd2);
        bus.valid = 1'b0;
        steps(2);

        // Rising edge lands exactly in the DONE cycle.
        clear_mon();
        c = 6'($urandom); r = 8'($urandom); h = rnd128();
        trigger(c, r, h, k);
        push_exp(c, r, h);
        steps(200);
        bus.valid = 1'b0;
        wait_sent(1, FRAME, "coinc_first");
        c = 6'($urandom); r = 8'($urandom); h = rnd128();
        bus.challenge = c; bus.response = r; bus.hash = h; bus.valid = 1'b1;
        push_exp(c, r, h);
        wait_sent(2, FRAME + 50, "coinc");
        steps(4);
        check("coinc_gap", 64'(start_of(1) - sent_at(0)), 64'd1);
        check("coinc_second_start", 64'(start_of(1) - k), 64'(FRAME + 1));
        compare_rx("coinc");
        bus.valid = 1'b0;
        steps(2);

        // Reset mid-frame, release with valid still high.
        clear_mon();
        c = 6'($urandom); r = 8'($urandom); h = rnd128();
        trigger(c, r, h, k);
        steps(700);
        rst = 1'b1;
        step();
        check("rstmid_tx", 64'(bus.tx), 64'd1);
        check("rstmid_busy", 64'(bus.busy), 64'd0);
        check("rstmid_sent", 64'(bus.sent), 64'd0);
        steps(2);
        rst = 1'b0;
        steps(60);
        clear_mon();
        steps(2000);
        check("rstmid_no_frame", 64'(sent_cnt - sent_b), 64'd0);
        check("rstmid_no_busy", 64'(busy_cnt - busy_b), 64'd0);
        check("rstmid_no_chars", 64'(rx_bytes.size() - rx_b), 64'd0);
        c = 6'($urandom); r = 8'($urandom); h = rnd128();
        trigger(c, r, h, k);
        push_exp(c, r, h);
        wait_sent(1, FRAME + 50, "rstmid_after");
        steps(4);
        compare_rx("rstmid_after");

        // Hex boundary values.
        clear_mon();
        trigger(6'h3F, 8'h00, '1, k);
        push_exp(6'h3F, 8'h00, '1);
        wait_sent(1, FRAME + 50, "hexedge");
        steps(4);
        compare_rx("hexedge");

        // Random frames.
        for (int f = 0; f < 3; f++) begin
            clear_mon();
            c = 6'($urandom); r = 8'($urandom); h = rnd128();
            trigger(c, r, h, k);
            push_exp(c, r, h);
            wait_sent(1, FRAME + 50, $sformatf("rand%0d", f));
            steps(4);
            check($sformatf("rand%0d_sent_offset", f), 64'(sent_at(0) - k), 64'(FRAME));
            compare_rx($sformatf("rand%0d", f));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/puf_hash_uart_tx.md
# puf_hash_uart_tx

Downstream consumer of the PUF hash stage. When the PUF asserts its `done`/valid level, this block snapshots the 6-bit challenge, 8-bit response and 128-bit hash. It streams them to the host as one ASCII-hex line over an 8N1 UART transmitter, so the full digest is logged rather than read one byte pair at a time from the seven-segment display.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200); legal range ≥ 2.

Ports:
- `clk` in 1: global clock.
- `rst` in 1: synchronous, active-high reset.
- `valid` in 1: level from the PUF `done`; high while `challenge`/`response`/`hash` are stable.
- `challenge` in 6: challenge switches.
- `response` in 8: PUF response byte.
- `hash` in 128: SHA128 digest.
- `tx` out 1: UART serial line, idle high.
- `busy` out 1: frame in progress.
- `sent` out 1: one-cycle pulse at frame completion.

One clock; reset is synchronous and active-high.

## Operation

- **Reset values:** `tx`=1, `busy`=0, `sent`=0, pending flag=0, `valid_d`=1 (no frame from a `valid` already high at reset release), FSM=IDLE, all counters 0.
- **Trigger:**
  - The trigger is a rising edge: `valid`=1 and `valid_d`=0.
  - In IDLE, the edge captures `{challenge, response, hash}` into a 142-bit snapshot and starts a frame.
- **Frame:** 40 characters, transmitted in this order:
  - 2 hex chars of `{2'b00, challenge}`;
  - ':' (0x3A);
  - 2 hex chars of `response`;
  - ':';
  - 32 hex chars of `hash`, nibble [127:124] first;
  - CR (0x0D), LF (0x0A).
- **Hex encoding:** nibble 0–9 → 0x30–0x39; A–F → 0x41–0x46 (uppercase).
- **Character format:**
  - 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
  - Each bit lasts exactly `CLKS_PER_BIT` cycles.
  - No idle gap between characters.
- **States:**
  - IDLE → START on the trigger.
  - START → DATA after 1 bit time.
  - DATA → STOP after 8 bit times; the bit index runs 0..7.
  - STOP → START (next char) when the char index < 39.
  - STOP → DONE when the char index = 39.
  - DONE → IDLE, or → START with a fresh capture if pending=1 and `valid`=1.
- **Char index:** a 6-bit counter 0..39, cleared on each new frame.
- **Baud counter:** reloads at every bit boundary. Its width is clog2(`CLKS_PER_BIT`).
- **Snapshot:** input changes after capture never affect the frame in flight. `valid` falling mid-frame has no effect and the frame completes.
- **Rising edge while busy:**
  - Sets pending; this is not a queue, and multiple edges collapse into one.
  - At frame end, if pending=1 and `valid`=1: clear pending, recapture the current inputs, start a new frame.
  - If pending=1 and `valid`=0: clear pending, go IDLE.
- **`valid` held high:** exactly one frame per rising edge.
- **Reset mid-frame:** `tx` returns to 1 on the next edge and the partial character is abandoned. The host sees a framing error, which is acceptable.

## Timing

- **Trigger edge:** let the trigger be sampled at posedge k.
  - At posedge k: `busy`←1 and `tx`←0 (start bit).
  - The latency from `valid` high to the start bit is 1 cycle.
- **`tx` is registered:** it changes only at bit boundaries, posedge k + n·`CLKS_PER_BIT` for n = 0..399.
- **Stop bit of character 39:** it ends at posedge k+400·`CLKS_PER_BIT`. At that edge:
  - `busy`←0 and `sent`←1 for exactly one cycle.
  - `tx` stays 1.
- **Back-to-back frame (pending):** the next start bit begins at posedge k+400·`CLKS_PER_BIT`+1. `busy` drops for that one cycle (the DONE cycle).
- **Edge coinciding with completion:** a rising edge in the same cycle as DONE sets pending and is serviced in that DONE→START decision. It is never dropped.

## Test plan

All scenarios use `CLKS_PER_BIT`=4; the bench decodes `tx` with a UART model.

1. **Basic frame.** Stimulus: `challenge`=6'h2A, `response`=8'hC3, `hash`=128'h0123456789ABCDEF_FEDCBA9876543210, `valid` 0→1. Required response:
   - the decoded line is "2A:C3:0123456789ABCDEFFEDCBA9876543210\r\n";
   - `busy` is high for 1600 cycles;
   - `sent` pulses once at cycle 1600 after the trigger.
2. **Snapshot holds.** Stimulus: same as scenario 1, then change `hash` to all-1s and drop `valid` at cycle 100. Required response: the line is unchanged from scenario 1 and no second frame is sent.
3. **`valid` held.** Stimulus: `valid` held high for 5000 cycles. Required response: exactly one frame and one `sent` pulse.
4. **Pending frame.**
   - Stimulus: during a frame, drive `valid` 1→0→1 and set `response`=8'h5E before frame end.
   - Required response: the second line starts 1 cycle after `sent`, with "…:5E:…", and exactly 2 frames total.
5. **Reset mid-frame.**
   - Stimulus: assert `rst` at cycle 700 of a frame, then release with `valid`=1.
   - Required response: `tx`=1, `busy`=0 and `sent`=0 one cycle after `rst`; no frame until a new 0→1 on `valid`.
6. **Hex edges.** Stimulus: `challenge`=6'h3F, `response`=8'h00, `hash`=all F's. Required response: "3F:00:FFFF…F\r\n" with 32 F's and uppercase hex only.
